enigma_key_entry: RTL
=====================

Name: enigma_key_entry

Overview:
- Input-capture stage directly upstream of the enigma machine.
- Turns raw DE2 pushbuttons and switches into a clean letter code `char_input`, a single registered `char_pressed` pulse that steps the rotor, and the rotor-load controls (`rotor_init_state`, `load_init_state`).
- Synchronises and debounces the buttons.
- Validates and case-folds the letter.
- Guarantees `char_input` is stable before every `char_pressed` rising edge.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required before a debounced button changes state (10 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser (minimum 2).
- REPEAT_CYCLES, 12500000, auto-repeat period in clocks; used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- resetn  input  1  asynchronous active-low reset.
- key_n  input  1  raw character-enter pushbutton, active-low, asynchronous.
- load_key_n  input  1  raw rotor-load pushbutton, active-low, asynchronous.
- sw_char  input  7  ASCII letter code from switches.
- sw_rotor  input  5  requested rotor start position.
- char_input  output  7  registered, validated uppercase ASCII letter.
- char_pressed  output  1  registered one-cycle step pulse.
- rotor_init_state  output  5  registered rotor start position, 0..25.
- load_init_state  output  1  registered; high while the debounced load button is held.
- invalid_char  output  1  sticky flag: the last press carried a non-letter.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on `resetn`.
- Reset values:
  - `char_input` = 7'h41 ('A'); `char_pressed` = 0; `rotor_init_state` = 0; `load_init_state` = 0; `invalid_char` = 0.
  - FSM in IDLE; debounced buttons read "released"; all counters 0.
  - Reset asserted mid-operation aborts any pulse immediately. No pulse is emitted on reset release.
- Synchroniser: each button passes through SYNC_STAGES flops before debouncing.
- Debounce:
  - The counter increments while the synchronised level differs from the debounced level and clears when it matches.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Press detect = debounced key transitioning released→pressed; a single-cycle internal event.
- FSM states IDLE, CHECK, PULSE, WAIT_RELEASE:
  - IDLE → CHECK on a key press event while the debounced load button is released. `sw_char` is latched into a holding register on the same edge.
  - IDLE → WAIT_RELEASE on a key press event while load is held. The press is ignored: no pulse, `char_input` and `invalid_char` unchanged.
  - CHECK, held value 8'h41..8'h5A: `char_input` ← value; `invalid_char` ← 0; go to PULSE.
  - CHECK, held value 8'h61..8'h7A: `char_input` ← value − 32; `invalid_char` ← 0; go to PULSE.
  - CHECK, any other value: `char_input` keeps its old value; `invalid_char` ← 1; go to WAIT_RELEASE.
  - PULSE: `char_pressed` = 1 for exactly this one cycle; go to WAIT_RELEASE. `char_input` has therefore been stable at least one full cycle before the rising edge.
  - WAIT_RELEASE → IDLE when the debounced key reads released. Without the optional feature, no further pulse occurs while the key is held.
- Latency: debounced press edge → `char_pressed` high = 2 clocks.
- `char_input` changes only in CHECK and holds between accepted presses.
- Rotor load:
  - `load_init_state` follows the debounced load level, registered (one clock after the debounced flip).
  - While `load_init_state` is high, `rotor_init_state` ← `sw_rotor` mod 26 every cycle, so 26..31 map to 0..5. It holds its value when load is low.
- Simultaneous events: load press and key press in the same cycle count as "load held", so the key press is ignored.
- `char_pressed` is never asserted while `load_init_state` is high.

Optional Feature:
- Macro: ENIGMA_AUTO_REPEAT_EN.
- Defined:
  - In WAIT_RELEASE, after an accepted letter, a repeat counter runs while the key is held.
  - Every REPEAT_CYCLES clocks it re-enters PULSE with the same `char_input`.
  - Release or load press clears the counter.
  - Invalid presses never repeat.
- Undefined: the counter is not built; exactly one pulse is produced per press.

Decomposition:
- Package `enigma_pkg` holds:
  - ASCII constants ASCII_UPPER_A/Z, ASCII_LOWER_A/Z, CASE_OFFSET = 32, ROTOR_POSITIONS = 26;
  - the FSM state enum typedef;
  - the `letter_t` typedef (7-bit) shared with the letter shifter.
- Sub-module `button_debouncer` (synchroniser plus debounce counter, output = debounced level) is instantiated twice, for `key_n` and `load_key_n`.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2, REPEAT_CYCLES = 8.
1. Reset then idle: `resetn` low for 3 cycles, then high → outputs 'A' (7'h41), 0, 0, 0, 0; `char_pressed` never rises over 50 cycles.
2. Valid uppercase: `sw_char` = 7'h51 ('Q'); key low for 20 cycles with 2-cycle bounce glitches first → exactly one `char_pressed` pulse; `char_input` = 7'h51 one cycle before it; the pulse arrives 2 clocks after the debounced edge.
3. Case fold and invalid: press with 7'h6D ('m') → `char_input` = 7'h4D and one pulse. Press with 7'h35 ('5') → no pulse, `invalid_char` = 1, `char_input` stays 7'h4D. Press with 7'h41 → `invalid_char` returns to 0.
4. Rotor load: `sw_rotor` = 29, load held 10 cycles → `load_init_state` high and `rotor_init_state` = 3. A key press during the hold gives no pulse. After release, `load_init_state` = 0 and `rotor_init_state` holds 3.
5. Reset mid-operation: assert `resetn` low in the CHECK cycle → `char_pressed` stays 0 and outputs return to reset values at once. Holding the key through reset release gives no pulse until release and a new press.
6. With ENIGMA_AUTO_REPEAT_EN, hold 'E' (7'h45) for 40 post-debounce cycles → an initial pulse plus one pulse every 8 cycles. Without the macro → exactly one pulse.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared definitions for the enigma key-entry front end.
//
// Contents:
//   letter_t           7-bit ASCII letter code, shared with the letter shifter
//   ASCII_* constants  letter range limits used for validation and case folding
//   CASE_OFFSET        distance between lower- and upper-case ASCII letters
//   ROTOR_POSITIONS    number of rotor positions (A..Z)
//   key_state_e        key-entry FSM state encoding
//   rotor_wrap()       folds a 5-bit switch value into 0..ROTOR_POSITIONS-1
package enigma_pkg;

  typedef logic [6:0] letter_t;

  localparam letter_t ASCII_UPPER_A   = 7'h41;
  localparam letter_t ASCII_UPPER_Z   = 7'h5A;
  localparam letter_t ASCII_LOWER_A   = 7'h61;
  localparam letter_t ASCII_LOWER_Z   = 7'h7A;
  localparam letter_t CASE_OFFSET     = 7'd32;
  localparam int      ROTOR_POSITIONS = 26;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CHECK        = 2'd1,
    PULSE        = 2'd2,
    WAIT_RELEASE = 2'd3
  } key_state_e;

  // A 5-bit value never exceeds 31, so one conditional subtraction is a full
  // modulo-26 reduction.
  function automatic logic [4:0] rotor_wrap(input logic [4:0] pos);
    if (pos >= 5'(ROTOR_POSITIONS)) begin
      return pos - 5'(ROTOR_POSITIONS);
    end
    return pos;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser plus debounce counter for one active-low pushbutton.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples needed to flip the level
//   SYNC_STAGES      synchroniser depth (2 or more)
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low reset
//   button_n      raw active-low button, asynchronous to clk
//   pressed       debounced level, 1 = pressed (reads released after reset)
//   press_evt     high in the cycle whose closing edge flips pressed 0->1
//   sync_pressed  synchronised (not yet debounced) level, 1 = pressed
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic button_n,
  output logic pressed,
  output logic press_evt,
  output logic sync_pressed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   flip;

  assign sync_pressed = ~sync_q[SYNC_STAGES-1];
  assign flip         = (sync_pressed != pressed) && (cnt == CNT_LAST);
  assign press_evt    = flip && !pressed;

  // The synchroniser resets to the "pressed" raw level: until real samples
  // have flushed through, the button is not assumed to be released. The
  // debounced level itself still resets to released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
      if (sync_pressed == pressed) begin
        cnt <= '0;
      end else if (flip) begin
        pressed <= ~pressed;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/enigma_key_entry.sv
// Input-capture stage in front of the enigma machine: turns raw pushbuttons
// and switches into a validated upper-case letter, a one-cycle step pulse and
// the rotor-load controls.
//
// Optional feature macro: ENIGMA_AUTO_REPEAT_EN (auto-repeat while the key is
// held after an accepted letter). Undefined: one pulse per press.
//
// Ports:
//   clk               system clock
//   resetn            asynchronous active-low reset
//   key_n             raw character-enter button, active-low
//   load_key_n        raw rotor-load button, active-low
//   sw_char           ASCII letter from switches
//   sw_rotor          requested rotor start position
//   char_input        registered validated upper-case letter (reset 'A')
//   char_pressed      registered one-cycle step pulse
//   rotor_init_state  registered rotor start position 0..25
//   load_init_state   registered debounced load level
//   invalid_char      sticky: last processed press was not a letter
//   dbg_state         current key-entry FSM state
module enigma_key_entry
  import enigma_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_n,
  input  logic       load_key_n,
  input  logic [6:0] sw_char,
  input  logic [4:0] sw_rotor,
  output letter_t    char_input,
  output logic       char_pressed,
  output logic [4:0] rotor_init_state,
  output logic       load_init_state,
  output logic       invalid_char,
  output key_state_e dbg_state
);

  logic key_db, key_evt, key_sync;
  logic load_db, load_evt, load_sync_unused;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key_db (
    .clk         (clk),
    .resetn      (resetn),
    .button_n    (key_n),
    .pressed     (key_db),
    .press_evt   (key_evt),
    .sync_pressed(key_sync)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_load_db (
    .clk         (clk),
    .resetn      (resetn),
    .button_n    (load_key_n),
    .pressed     (load_db),
    .press_evt   (load_evt),
    .sync_pressed(load_sync_unused)
  );

  key_state_e state, state_nxt;
  letter_t    held_char;
  logic       armed;
  logic       load_held;
  logic       is_upper, is_lower, is_letter;
  logic       repeat_fire;

  // A load press landing on the same edge as a key press counts as held.
  assign load_held = load_db | load_evt;
  assign is_upper  = (held_char >= ASCII_UPPER_A) && (held_char <= ASCII_UPPER_Z);
  assign is_lower  = (held_char >= ASCII_LOWER_A) && (held_char <= ASCII_LOWER_Z);
  assign is_letter = is_upper | is_lower;
  assign dbg_state = state;

`ifdef ENIGMA_AUTO_REPEAT_EN
  localparam int RCW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_CYCLES - 2);

  logic [RCW-1:0] rep_cnt;
  logic           rep_ok;
  logic           rep_run;

  // PULSE plus REPEAT_CYCLES-1 counting cycles in WAIT_RELEASE gives a pulse
  // period of exactly REPEAT_CYCLES clocks.
  assign rep_run     = (state == WAIT_RELEASE) && key_db && !load_db && rep_ok;
  assign repeat_fire = rep_run && (rep_cnt == REP_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rep_cnt <= '0;
      rep_ok  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        rep_ok <= 1'b0;
      end else if (state == CHECK) begin
        rep_ok <= is_letter;
      end
      if (rep_run && !repeat_fire) begin
        rep_cnt <= rep_cnt + RCW'(1);
      end else begin
        rep_cnt <= '0;
      end
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_CYCLES > 0);
  assign repeat_fire   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (key_evt) begin
          // Ignored presses still go through WAIT_RELEASE so the held key
          // cannot produce a second event without a release first.
          if (load_held || !armed) begin
            state_nxt = WAIT_RELEASE;
          end else begin
            state_nxt = CHECK;
          end
        end
      end
      CHECK:        state_nxt = is_letter ? PULSE : WAIT_RELEASE;
      PULSE:        state_nxt = WAIT_RELEASE;
      WAIT_RELEASE: begin
        if (!key_db) begin
          state_nxt = IDLE;
        end else if (repeat_fire) begin
          state_nxt = PULSE;
        end
      end
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      held_char        <= '0;
      char_input       <= ASCII_UPPER_A;
      invalid_char     <= 1'b0;
      char_pressed     <= 1'b0;
      load_init_state  <= 1'b0;
      rotor_init_state <= '0;
      armed            <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && state_nxt == CHECK) begin
        held_char <= sw_char;
      end

      // char_input changes here, one cycle before PULSE drives char_pressed.
      if (state == CHECK) begin
        if (is_upper) begin
          char_input   <= held_char;
          invalid_char <= 1'b0;
        end else if (is_lower) begin
          char_input   <= held_char - CASE_OFFSET;
          invalid_char <= 1'b0;
        end else begin
          invalid_char <= 1'b1;
        end
      end

      // Gating on load_db keeps the pulse out of any load_init_state cycle.
      char_pressed    <= (state == PULSE) && !load_db;
      load_init_state <= load_db;
      if (load_db) begin
        rotor_init_state <= rotor_wrap(sw_rotor);
      end

      // A key held through reset must be seen released before it can step.
      if (!key_db && !key_sync) begin
        armed <= 1'b1;
      end
    end
  end

endmodule
